// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, its client channels and memory port B.
// The slave modport is the arbiter's view; master is the client/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 16
);
  logic [N_CH-1:0]    req_valid;
  logic [N_CH-1:0]    req_ready;
  logic [N_CH-1:0]    req_we;
  logic [N_CH*AW-1:0] req_addr;
  logic [N_CH*DW-1:0] req_wdata;
  logic [N_CH-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [AW-1:0]      mem_b_addr;
  logic [DW-1:0]      mem_b_wdata;
  logic               mem_b_we;
  logic [DW-1:0]      mem_b_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_b_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_b_addr, mem_b_wdata, mem_b_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_b_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_b_addr, mem_b_wdata, mem_b_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port B among N_CH clients, 2-clock read pipeline.
// Optional MEMSUB_ADDR_GUARD_EN: out-of-range requests are answered with rsp_err, not issued.
module mem_port_arbiter #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 16,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx, cand;
  logic            gnt_any;
  logic [N_CH-1:0] ready;

  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;
  logic            sel_bad;

  logic            s1_valid_q, s1_err_q;
  logic [PW-1:0]   s1_ch_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            mem_we_q;
  logic [N_CH-1:0] rsp_valid_q;
  logic            rsp_err_q;

  // Search upward from the pointer, wrapping; reset forces all grants low.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    ready   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = PW'((32'(ptr_q) + i) % N_CH);
      if (!gnt_any && bus.req_valid[cand] && !reset) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) ready[gnt_idx] = 1'b1;
    ptr_d = gnt_any ? PW'((32'(gnt_idx) + 32'd1) % N_CH) : ptr_q;
  end

  assign bus.req_ready = ready;

  assign sel_addr  = bus.req_addr[32'(gnt_idx)*AW +: AW];
  assign sel_wdata = bus.req_wdata[32'(gnt_idx)*DW +: DW];
  assign sel_we    = bus.req_we[gnt_idx];

`ifdef MEMSUB_ADDR_GUARD_EN
  assign sel_bad = (64'(sel_addr) >= 64'(MEM_DEPTH));
`else
  assign sel_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_ch_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= gnt_any;
      s1_err_q   <= gnt_any & sel_bad;
      s1_ch_q    <= gnt_idx;
      // Address/data hold their last values unless a request is actually issued.
      if (gnt_any && !sel_bad) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
        mem_we_q    <= sel_we;
      end else begin
        mem_we_q    <= 1'b0;
      end
      rsp_valid_q <= s1_valid_q ? (N_CH'(1) << s1_ch_q) : '0;
      rsp_err_q   <= s1_valid_q & s1_err_q;
    end
  end

  assign bus.mem_b_addr  = mem_addr_q;
  assign bus.mem_b_wdata = mem_wdata_q;
  assign bus.mem_b_we    = mem_we_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  // Memory read data arrives registered, aligned with the response strobe.
  assign bus.rsp_rdata   = (|rsp_valid_q && !rsp_err_q) ? bus.mem_b_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a port-B memory and request model.
module tb_mem_port_arbiter;
  localparam int NCh = 2;

`ifdef MEMSUB_ADDR_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    int          ch;
    bit          we;
    logic [15:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_port_arbiter_if #(.N_CH(2), .DW(16), .AW(16)) bus ();

  mem_port_arbiter #(
    .N_CH(2), .DW(16), .AW(16), .MEM_DEPTH(1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Port-B memory: synchronous write, registered read.
  logic [15:0] mem_arr [65536];
  always @(posedge clk) begin
    if (bus.mem_b_we) mem_arr[bus.mem_b_addr] <= bus.mem_b_wdata;
    bus.mem_b_rdata <= mem_arr[bus.mem_b_addr];
  end

  // Reference model state
  logic [15:0] ref_mem [65536];
  exp_t        sbq[$];
  req_t        scr0[$], scr1[$];
  bit          cv[NCh];
  req_t        creq[NCh];
  int          mptr = 0;
  bit          exp_we = 1'b0;
  logic [15:0] exp_addr, exp_wdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic drive_bus();
    for (int c = 0; c < NCh; c++) begin
      bus.req_valid[c]           = cv[c];
      bus.req_we[c]              = creq[c].we;
      bus.req_addr[c*16 +: 16]   = creq[c].addr;
      bus.req_wdata[c*16 +: 16]  = creq[c].wdata;
    end
  endtask

  task automatic sync_ref();
    for (int a = 0; a < 65536; a++) ref_mem[a] = mem_arr[a];
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we    = ($urandom % 2) == 1;
    r.addr  = (($urandom % 16) == 0) ? 16'(1022 + ($urandom % 4)) : 16'($urandom % 32);
    r.wdata = 16'($urandom);
    return r;
  endfunction

  // One clock of stimulus plus the grant and issue checks.
  task automatic cycle(input bit rand_en);
    int          g;
    logic [1:0]  exp_rdy;
    exp_t        e;
    bit          err;
    @(posedge clk);
    #1;
    check("mem_b_we", 32'(bus.mem_b_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_b_addr", 32'(bus.mem_b_addr), 32'(exp_addr));
      check("mem_b_wdata", 32'(bus.mem_b_wdata), 32'(exp_wdata));
    end
    if (!cv[0] && scr0.size() > 0) begin creq[0] = scr0.pop_front(); cv[0] = 1'b1; end
    if (!cv[1] && scr1.size() > 0) begin creq[1] = scr1.pop_front(); cv[1] = 1'b1; end
    for (int c = 0; c < NCh; c++)
      if (!cv[c] && rand_en && ($urandom % 10) < 7) begin creq[c] = rand_req(); cv[c] = 1'b1; end
    drive_bus();
    #1;
    g = -1;
    for (int i = 0; i < NCh; i++)
      if (g < 0 && cv[(mptr + i) % NCh]) g = (mptr + i) % NCh;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    exp_we = 1'b0;
    if (g >= 0) begin
      err    = Guard && (creq[g].addr >= 16'd1024);
      e.ch   = g;
      e.we   = creq[g].we;
      e.data = err ? 16'h0 : ref_mem[creq[g].addr];
      e.err  = err;
      e.cyc  = cyc + 2;
      sbq.push_back(e);
      if (!err) begin
        if (creq[g].we) ref_mem[creq[g].addr] = creq[g].wdata;
        exp_we    = creq[g].we;
        exp_addr  = creq[g].addr;
        exp_wdata = creq[g].wdata;
      end
      mptr  = (g + 1) % NCh;
      cv[g] = 1'b0;
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'h0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'h0);
    check({tag, "_mem_b_we"}, 32'(bus.mem_b_we), 32'h0);
    check({tag, "_mem_b_addr"}, 32'(bus.mem_b_addr), 32'h0);
    check({tag, "_mem_b_wdata"}, 32'(bus.mem_b_wdata), 32'h0);
  endtask

  // Asynchronous reset in the middle of a clock period, with requests pending.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_quiet_outputs("midrst");
    sbq.delete();
    scr0.delete();
    scr1.delete();
    for (int c = 0; c < NCh; c++) cv[c] = 1'b0;
    drive_bus();
    mptr   = 0;
    exp_we = 1'b0;
    repeat (2) @(negedge clk);
    sync_ref();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is presented.
  always @(negedge clk) begin
    if (!reset) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_missing got none want ch%0d at cycle %0d", sbq[0].ch, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (bus.rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.ch);
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          if (!e.we || e.err) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < NCh; c++) begin
      cv[c]   = 1'b0;
      creq[c] = '{we: 1'b0, addr: 16'h0, wdata: 16'h0};
    end
    drive_bus();
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    drive_bus();
    @(negedge clk);
    sync_ref();
    reset = 1'b0;

    // Single read of a known word, issued after a write from the other channel.
    scr1.push_back('{we: 1'b1, addr: 16'h0010, wdata: 16'hBEEF});
    cycle(1'b0);
    repeat (3) cycle(1'b0);
    scr0.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0});
    repeat (4) cycle(1'b0);

    // Write then read of the same address on consecutive cycles.
    scr1.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'h1234});
    cycle(1'b0);
    scr0.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0});
    repeat (4) cycle(1'b0);

    // Back-to-back reads from one channel.
    for (int a = 0; a < 8; a++) scr0.push_back('{we: 1'b0, addr: 16'(a), wdata: 16'h0});
    repeat (11) cycle(1'b0);

    // Boundary address: out of range only when the guard is built in.
    scr0.push_back('{we: 1'b1, addr: 16'h0400, wdata: 16'h5555});
    scr0.push_back('{we: 1'b0, addr: 16'h0400, wdata: 16'h0});
    scr1.push_back('{we: 1'b0, addr: 16'h03FF, wdata: 16'h0});
    repeat (6) cycle(1'b0);

    repeat (600) cycle(1'b1);
    mid_reset();
    repeat (400) cycle(1'b1);

    for (int c = 0; c < NCh; c++) cv[c] = 1'b0;
    for (int i = 0; i < 12 && sbq.size() > 0; i++) cycle(1'b0);
    if (sbq.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
